// File: rtl/agc_pkg.sv
// Shared constants, FSM state type and window-exponent clamp for the AGC power meter.
// Pure declarations: no latency, no flow control.
package agc_pkg;

    localparam int WIN_MIN = 4;
    localparam int WIN_MAX = 12;
    localparam int ACC_W   = 43;
    localparam int SQ_W    = 31;
    localparam int CNT_W   = 12;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } agc_state_e;

    function automatic logic [3:0] clamp_win(input logic [3:0] w, input int lo, input int hi);
        int wi;
        wi = int'(w);
        if (wi < lo) begin
            wi = lo;
        end else if (wi > hi) begin
            wi = hi;
        end
        return wi[3:0];
    endfunction

endpackage

// File: rtl/agc_sq_stage.sv
// Registered squarer: sq = x_in^2 as an unsigned value, one cycle of latency.
// No backpressure; sq_valid follows valid one edge later.
module agc_sq_stage #(
    parameter int DATA_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [DATA_W-1:0]   x_in,
    input  logic                       valid,
    output logic [agc_pkg::SQ_W-1:0]   sq,
    output logic                       sq_valid
);
    import agc_pkg::*;

    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0] prod;
    logic [SQ_W-1:0]      sq_q, sq_d;
    logic                 sq_vld_q, sq_vld_d;

    // -32768^2 = 2^30 is the largest result, so the top product bit is always zero.
    assign prod     = PW'(x_in) * PW'(x_in);
    assign sq_d     = SQ_W'(prod);
    assign sq_vld_d = valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sq_q     <= '0;
            sq_vld_q <= 1'b0;
        end else begin
            sq_q     <= sq_d;
            sq_vld_q <= sq_vld_d;
        end
    end

    assign sq       = sq_q;
    assign sq_valid = sq_vld_q;

endmodule

// File: rtl/agc_power_meter.sv
// Mean-square power over 2^w samples with over/under-reference flags; result 2 edges after last sample.
// No backpressure: every x_valid sample is accepted while enabled; dropping enable aborts the window.
module agc_power_meter #(
    parameter int DATA_W  = 16,
    parameter int WIN_MIN = agc_pkg::WIN_MIN,
    parameter int WIN_MAX = agc_pkg::WIN_MAX
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic                     x_valid,
    input  logic                     enable,
    input  logic [3:0]               win_log2,
    input  logic [15:0]              reference,
    output logic [31:0]              power_out,
    output logic                     power_valid,
    output logic                     over_ref,
    output logic                     under_ref,
    output logic                     busy
);
    import agc_pkg::*;

    localparam logic [CNT_W:0] ONE = {{CNT_W{1'b0}}, 1'b1};

    agc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       w_q, w_d, w_new;
    logic [31:0]      pow_q, pow_d, pow_new;
    logic             pv_q, pv_d;
    logic             over_q, over_d;
    logic             under_q, under_d;

    logic [SQ_W-1:0]  sq;
    logic             sq_vld;
    logic [CNT_W:0]   win_len, win_last;
    logic             win_done;
    logic [15:0]      ref_half;
    logic [31:0]      ref_pow;

    agc_sq_stage #(
        .DATA_W (DATA_W)
    ) u_sq (
        .clk      (clk),
        .rst      (rst),
        .x_in     (x_in),
        .valid    (x_valid && enable),
        .sq       (sq),
        .sq_valid (sq_vld)
    );

    assign w_new    = clamp_win(win_log2, WIN_MIN, WIN_MAX);
    assign win_len  = ONE << w_q;
    assign win_last = win_len - ONE;
    assign win_done = sq_vld && ({1'b0, cnt_q} == win_last);

    // The closing sample is folded in here so the result lands on the same edge it is accumulated.
    assign sum      = acc_q + ACC_W'(sq);
    assign pow_new  = 32'(sum >> w_q);

    assign ref_half = reference >> 1;
    assign ref_pow  = {16'd0, ref_half} * {16'd0, ref_half};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        pow_d   = pow_q;
        pv_d    = 1'b0;
        over_d  = over_q;
        under_d = under_q;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ACCUM;
                    w_d     = w_new;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                if (!enable) begin
                    state_d = IDLE;
                end
                // A completing window wins over an enable drop on the same edge.
                if (win_done) begin
                    pow_d   = pow_new;
                    pv_d    = 1'b1;
                    over_d  = pow_new > ref_pow;
                    under_d = pow_new < (ref_pow >> 2);
                    acc_d   = '0;
                    cnt_d   = '0;
                    w_d     = w_new;
                end else if (!enable) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (sq_vld) begin
                    acc_d   = sum;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            w_q     <= WIN_MIN[3:0];
            pow_q   <= '0;
            pv_q    <= 1'b0;
            over_q  <= 1'b0;
            under_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            pow_q   <= pow_d;
            pv_q    <= pv_d;
            over_q  <= over_d;
            under_q <= under_d;
        end
    end

    assign power_out   = pow_q;
    assign power_valid = pv_q;
    assign over_ref    = over_q;
    assign under_ref   = under_q;
    assign busy        = (state_q == ACCUM);

endmodule

// File: tb/tb_agc_power_meter.sv
// Bench for agc_power_meter: directed scenarios plus random traffic against a window-level model.
module tb_agc_power_meter;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [15:0] x_in = '0;
    logic               x_valid = 1'b0;
    logic               enable = 1'b0;
    logic [3:0]         win_log2 = 4'd4;
    logic [15:0]        reference = 16'd2000;
    logic [31:0]        power_out;
    logic               power_valid;
    logic               over_ref;
    logic               under_ref;
    logic               busy;

    agc_power_meter #(
        .DATA_W  (16),
        .WIN_MIN (4),
        .WIN_MAX (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .x_in        (x_in),
        .x_valid     (x_valid),
        .enable      (enable),
        .win_log2    (win_log2),
        .reference   (reference),
        .power_out   (power_out),
        .power_valid (power_valid),
        .over_ref    (over_ref),
        .under_ref   (under_ref),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Window-level model: a window is a list of 2^w accepted samples; its mean square
    // appears one edge after the sample that fills it.
    bit     m_active, m_pend, m_pv, m_over, m_under;
    int     m_w, m_cnt, pend_w;
    longint m_sum, pend_sum, m_pow;

    function automatic int clampw(input int w);
        return (w < 4) ? 4 : ((w > 12) ? 12 : w);
    endfunction

    task automatic model_reset();
        m_active = 0; m_pend = 0; m_pv = 0; m_over = 0; m_under = 0;
        m_w = 4; m_cnt = 0; pend_w = 4; m_sum = 0; pend_sum = 0; m_pow = 0;
    endtask

    task automatic model_edge(input bit en, input bit xv, input int x, input int win, input int rf);
        longint rp;
        m_pv = 0;
        if (m_pend) begin
            rp      = longint'(rf / 2) * longint'(rf / 2);
            m_pow   = pend_sum >> pend_w;
            m_over  = (m_pow > rp);
            m_under = (m_pow < rp / 4);
            m_pv    = 1;
            m_pend  = 0;
            m_w     = clampw(win);
        end
        if (!en) begin
            m_active = 0;
            m_cnt    = 0;
            m_sum    = 0;
        end else begin
            if (!m_active) begin
                m_active = 1;
                m_w      = clampw(win);
                m_cnt    = 0;
                m_sum    = 0;
            end
            if (xv) begin
                m_sum += longint'(x) * longint'(x);
                m_cnt++;
                if (m_cnt == (1 << m_w)) begin
                    m_pend   = 1;
                    pend_sum = m_sum;
                    pend_w   = m_w;
                    m_cnt    = 0;
                    m_sum    = 0;
                end
            end
        end
    endtask

    task automatic cycle(input bit en, input bit xv, input int x, input int win, input int rf);
        enable    = en;
        x_valid   = xv;
        x_in      = 16'(x);
        win_log2  = 4'(win);
        reference = 16'(rf);
        @(posedge clk);
        #1;
        model_edge(en, xv, x, win, rf);
        check_eq("power_valid", power_valid, m_pv);
        check_eq("busy",        busy,        m_active);
        check_eq("power_out",   power_out,   m_pow);
        check_eq("over_ref",    over_ref,    m_over);
        check_eq("under_ref",   under_ref,   m_under);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit reached, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int rf;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_power_out",   power_out,   0);
        check_eq("reset_power_valid", power_valid, 0);
        check_eq("reset_over",        over_ref,    0);
        check_eq("reset_under",       under_ref,   0);
        check_eq("reset_busy",        busy,        0);
        rst = 1'b1;

        // Constant 1000, 16-sample windows back to back.
        for (int i = 0; i < 16; i++) cycle(1, 1, 1000, 4, 2000);
        check_eq("s1_no_early_pulse", power_valid, 0);
        cycle(1, 1, 1000, 4, 2000);
        check_eq("s1_first_pulse", power_valid, 1);
        check_eq("s1_power", power_out, 1000000);
        for (int i = 0; i < 15; i++) cycle(1, 1, 1000, 4, 2000);
        check_eq("s1_gap_no_pulse", power_valid, 0);
        cycle(1, 1, 1000, 4, 2000);
        check_eq("s1_second_pulse", power_valid, 1);
        cycle(0, 0, 0, 4, 2000);

        // Reference flags: 1001 is above, 400 is below a quarter of ref_pow.
        for (int i = 0; i < 16; i++) cycle(1, 1, 1001, 4, 2000);
        cycle(1, 1, 400, 4, 2000);
        check_eq("s3_over_pv", power_valid, 1);
        check_eq("s3_over", over_ref, 1);
        check_eq("s3_over_under", under_ref, 0);
        for (int i = 0; i < 15; i++) cycle(1, 1, 400, 4, 2000);
        cycle(1, 0, 0, 4, 2000);
        check_eq("s3_under_pv", power_valid, 1);
        check_eq("s3_under_power", power_out, 160000);
        check_eq("s3_under", under_ref, 1);
        check_eq("s3_under_over", over_ref, 0);
        cycle(0, 0, 0, 4, 2000);

        // Alternating +/-100, valid every other cycle.
        for (int i = 0; i < 33; i++)
            cycle(1, (i % 2 == 0) && (i < 32), (i % 4 == 0) ? 100 : -100, 4, 2000);
        check_eq("s4_power", power_out, 10000);
        cycle(0, 0, 0, 4, 2000);

        // Abort after 7 samples, then a full fresh window is needed.
        for (int i = 0; i < 7; i++) cycle(1, 1, 300, 4, 2000);
        cycle(0, 1, 300, 4, 2000);
        cycle(0, 0, 0, 4, 2000);
        check_eq("s5_abort_power", power_out, 10000);
        for (int i = 0; i < 16; i++) cycle(1, 1, 50, 4, 2000);
        check_eq("s5_fresh_no_pulse", power_valid, 0);
        cycle(1, 0, 0, 4, 2000);
        check_eq("s5_fresh_pulse", power_valid, 1);
        check_eq("s5_fresh_power", power_out, 2500);
        cycle(0, 0, 0, 4, 2000);

        // Reset mid-window.
        for (int i = 0; i < 5; i++) cycle(1, 1, 200, 4, 2000);
        rst = 1'b0;
        #1;
        check_eq("s6_rst_power_out",   power_out,   0);
        check_eq("s6_rst_power_valid", power_valid, 0);
        check_eq("s6_rst_over",        over_ref,    0);
        check_eq("s6_rst_under",       under_ref,   0);
        check_eq("s6_rst_busy",        busy,        0);
        model_reset();
        enable = 1'b0;
        x_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) cycle(1, 1, 10, 4, 2000);
        check_eq("s6_fresh_no_pulse", power_valid, 0);
        cycle(1, 0, 0, 4, 2000);
        check_eq("s6_fresh_pulse", power_valid, 1);
        check_eq("s6_fresh_power", power_out, 100);
        cycle(0, 0, 0, 4, 2000);

        // Full-scale negative input, window exponent 15 clamped to 4096 samples.
        for (int i = 0; i < 4096; i++) cycle(1, 1, -32768, 15, 2000);
        check_eq("s7_no_early_pulse", power_valid, 0);
        cycle(1, 0, 0, 15, 2000);
        check_eq("s7_pulse", power_valid, 1);
        check_eq("s7_power", power_out, 1073741824);
        cycle(0, 0, 0, 4, 2000);

        // Random traffic: gaps, enable drops, window changes, random reference.
        rf = 2000;
        for (int i = 0; i < 3000; i++) begin
            if (i % 256 == 0) rf = int'($urandom_range(0, 65535));
            cycle(($urandom % 48) != 0, ($urandom % 4) != 0,
                  int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 6)), rf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
